// File: rtl/exec_unit_if.sv
// Request/response bundle between the register-file read port and exec_unit.
// The master drives the request fields and the slave (exec_unit) drives the results.
interface exec_unit_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic              start;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] dest;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic              flag_z;
  logic              flag_n;
  logic              flag_c;
  logic              illegal;

  modport master (
    output start, opcode, dest, op_a, op_b,
    input  busy, done, result, wb_en, wb_addr, flag_z, flag_n, flag_c, illegal
  );
  modport slave (
    input  start, opcode, dest, op_a, op_b,
    output busy, done, result, wb_en, wb_addr, flag_z, flag_n, flag_c, illegal
  );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus optional iterative shift-add MUL, with write-back strobe
// and registered Z/N/C flags. Define EXEC_MUL_EN to build the MUL path (opcode 10).
module exec_unit #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  exec_unit_if.slave  io
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MULT} state_t;

  state_t            state_q, state_d;
  logic [3:0]        opc_q, opc_d;
  logic [ADDR_W-1:0] dest_q, dest_d, wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic              z_q, z_d, n_q, n_d, c_q, c_d;
  logic              done_q, done_d, wb_en_q, wb_en_d, illegal_q, illegal_d;
  logic              busy;
`ifdef EXEC_MUL_EN
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              start_mul;
  assign start_mul = (io.opcode == 4'd10);
  logic              legal;
  assign legal = (opc_q <= 4'd10);
`else
  logic              start_mul;
  assign start_mul = 1'b0;
  logic              legal;
  assign legal = (opc_q <= 4'd9);
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (io.start) state_d = start_mul ? S_MULT : S_EXEC;
      S_EXEC: state_d = S_IDLE;
`ifdef EXEC_MUL_EN
      S_MULT: if (cnt_q == 4'hF) state_d = S_EXEC;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // ALU; shift carries come from the bit that falls just outside the word
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [WIDTH:0]   shl_w, shr_w;
  always_comb begin
    shl_w   = {1'b0, a_q} << b_q[3:0];
    shr_w   = {a_q, 1'b0} >> b_q[3:0];
    alu_res = '0;
    alu_c   = 1'b0;
    case (opc_q)
      4'd0:       alu_res = b_q;
      4'd1:       {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      4'd2, 4'd9: {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q};
      4'd3:       alu_res = a_q & b_q;
      4'd4:       alu_res = a_q | b_q;
      4'd5:       alu_res = a_q ^ b_q;
      4'd6:       alu_res = ~a_q;
      4'd7:       {alu_c, alu_res} = shl_w;
      4'd8:       {alu_res, alu_c} = shr_w;
`ifdef EXEC_MUL_EN
      4'd10:      alu_res = acc_q;
`endif
      default:    alu_res = '0;
    endcase
  end

  always_comb begin
    opc_d     = opc_q;
    dest_d    = dest_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    wb_addr_d = wb_addr_q;
    z_d       = z_q;
    n_d       = n_q;
    c_d       = c_q;
    done_d    = 1'b0;
    wb_en_d   = 1'b0;
    illegal_d = 1'b0;
`ifdef EXEC_MUL_EN
    acc_d     = acc_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: if (io.start) begin
        opc_d  = io.opcode;
        dest_d = io.dest;
        a_d    = io.op_a;
        b_d    = io.op_b;
`ifdef EXEC_MUL_EN
        acc_d  = '0;
        cnt_d  = '0;
`endif
      end
`ifdef EXEC_MUL_EN
      // a_q is the shifting multiplicand, b_q the shifting multiplier
      S_MULT: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 4'd1;
      end
`endif
      S_EXEC: begin
        done_d    = 1'b1;
        wb_addr_d = dest_q;
        if (!legal) begin
          illegal_d = 1'b1;
        end else begin
          if (opc_q != 4'd9) begin
            result_d = alu_res;
            wb_en_d  = 1'b1;
          end
          z_d = (alu_res == '0);
          n_d = alu_res[WIDTH-1];
          c_d = alu_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q     <= '0;
      dest_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      wb_addr_q <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      c_q       <= 1'b0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifdef EXEC_MUL_EN
      acc_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      opc_q     <= opc_d;
      dest_q    <= dest_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      wb_addr_q <= wb_addr_d;
      z_q       <= z_d;
      n_q       <= n_d;
      c_q       <= c_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      illegal_q <= illegal_d;
`ifdef EXEC_MUL_EN
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign io.busy    = busy;
  assign io.done    = done_q;
  assign io.result  = result_q;
  assign io.wb_en   = wb_en_q;
  assign io.wb_addr = wb_addr_q;
  assign io.flag_z  = z_q;
  assign io.flag_n  = n_q;
  assign io.flag_c  = c_q;
  assign io.illegal = illegal_q;
endmodule

// File: tb/tb_exec_unit.sv
// Randomized self-checking bench for exec_unit against an arithmetic reference model;
// follows the EXEC_MUL_EN setting of the build.
module tb_exec_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  exec_unit_if #(.WIDTH(16), .ADDR_W(3)) bus ();
  exec_unit #(.WIDTH(16), .ADDR_W(3)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  always #5 clk = ~clk;

  // reference state
  logic [15:0] m_res = '0;
  logic        m_z = 0, m_n = 0, m_c = 0;

`ifdef EXEC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_wb_en"}, bus.wb_en, 0);
    check({tag, "_illegal"}, bus.illegal, 0);
    check({tag, "_result"}, bus.result, 0);
    check({tag, "_wb_addr"}, bus.wb_addr, 0);
    check({tag, "_flags"}, {bus.flag_z, bus.flag_n, bus.flag_c}, 0);
  endtask

  task automatic run_op(input logic [3:0] opc, input logic [2:0] d,
                        input logic [15:0] a, input logic [15:0] b, input bit junk);
    longint r;
    int     sh, lat, exp_lat;
    bit     legal, wb, c;
    logic [15:0] res;
    sh = int'(b[3:0]);
    legal = (opc <= 9) || (opc == 10 && MUL_ON);
    wb = legal && opc != 9;
    exp_lat = (opc == 10 && MUL_ON) ? 17 : 1;
    c = 0;
    r = 0;
    case (opc)
      0: r = b;
      1: begin r = longint'(a) + longint'(b); c = r > 65535; end
      2, 9: begin r = longint'(a) - longint'(b); c = a < b; end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = 65535 - longint'(a);
      7: begin r = longint'(a) * (longint'(1) << sh); c = (sh != 0) && ((r >> 16) % 2 == 1); end
      8: begin r = longint'(a) / (longint'(1) << sh); c = (sh != 0) && ((longint'(a) >> (sh - 1)) % 2 == 1); end
      10: r = longint'(a) * longint'(b);
      default: r = 0;
    endcase
    res = r[15:0];

    @(negedge clk);
    bus.start = 1; bus.opcode = opc; bus.dest = d; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #1;
    check("busy_accept", bus.busy, 1);
    check("done_early", bus.done, 0);
    if (junk) begin
      bus.opcode = 4'($urandom_range(0, 15));
      bus.op_a = 16'($urandom); bus.op_b = 16'($urandom); bus.dest = 3'($urandom);
    end else bus.start = 0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.done && lat < 40);
    bus.start = 0;
    if (legal) begin
      m_z = (res == 0); m_n = res[15]; m_c = c;
      if (wb) m_res = res;
    end
    check("latency", lat, exp_lat);
    check("done", bus.done, 1);
    check("wb_en", bus.wb_en, wb);
    check("illegal", bus.illegal, !legal);
    if (wb) check("wb_addr", bus.wb_addr, d);
    check("result", bus.result, m_res);
    check("flag_z", bus.flag_z, m_z);
    check("flag_n", bus.flag_n, m_n);
    check("flag_c", bus.flag_c, m_c);
    @(posedge clk); #1;
    check("done_pulse", bus.done, 0);
    check("wb_pulse", bus.wb_en, 0);
    check("busy_after", bus.busy, 0);
  endtask

  initial begin
    bit seen;
    bus.start = 0; bus.opcode = 0; bus.dest = 0; bus.op_a = 0; bus.op_b = 0;
    repeat (2) @(posedge clk);
    #2;
    chk_zero("rst");
    @(negedge clk); rst_n = 1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
      check("idle_wb", bus.wb_en, 0);
    end

    run_op(4'd1, 3'd3, 16'h7FFF, 16'h0001, 0);
    run_op(4'd2, 3'd1, 16'd5, 16'd7, 1);
    run_op(4'd9, 3'd2, 16'h1234, 16'h1234, 0);
    run_op(4'd10, 3'd4, 16'd300, 16'd300, 1);
    run_op(4'd15, 3'd5, 16'hAAAA, 16'h5555, 0);
    run_op(4'd10, 3'd6, 16'hFFFF, 16'hFFFF, 0);
    run_op(4'd7, 3'd0, 16'h8001, 16'd0, 0);
    run_op(4'd8, 3'd7, 16'h0003, 16'd1, 0);
    run_op(4'd7, 3'd7, 16'h0001, 16'd15, 0);

    for (int i = 0; i < 80; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      run_op(4'($urandom_range(0, 15)), 3'($urandom), a, b, bit'($urandom_range(0, 1)));
    end

    // abort an op in flight with an asynchronous reset
    run_op(4'd1, 3'd2, 16'd40, 16'd2, 0);
    @(negedge clk);
    bus.start = 1; bus.opcode = MUL_ON ? 4'd10 : 4'd1; bus.dest = 3'd5;
    bus.op_a = 16'd300; bus.op_b = 16'd300;
    @(posedge clk); #1;
    bus.start = 0;
    if (MUL_ON) repeat (7) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk_zero("abort");
    m_res = 0; m_z = 0; m_n = 0; m_c = 0;
    @(negedge clk); rst_n = 1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done || bus.wb_en) seen = 1;
    end
    check("abort_no_pulse", seen, 0);
    run_op(4'd1, 3'd1, 16'd1, 16'd1, 0);
    check("post_abort_res", bus.result, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
